// File: rtl/cf_math_pkg.sv
// cf_math_pkg: small elaboration-time math helpers shared across the codebase.
//   idx_width(n) : bits needed to index n items (at least 1)
//   ceil_div(a,b): integer ceiling division
package cf_math_pkg;

  function automatic int unsigned idx_width(input int unsigned num_idx);
    return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
  endfunction

  function automatic int unsigned ceil_div(input int unsigned dividend,
                                           input int unsigned divisor);
    return (dividend + divisor - 32'd1) / divisor;
  endfunction

endpackage

// File: rtl/dma_burst_pkg.sv
// dma_burst_pkg: shared types and constants for the DMA burst scheduler.
//   PageBytes     : AXI bursts must not cross this boundary
//   AxLenWidth    : width of the AXI AxLEN field
//   burst_state_e : scheduler FSM states
//   burst_req_t   : registered burst fields (addr held at the widest supported width)
//   beats_of()    : ceil(len / beat_bytes) via shift plus OR of the remainder bits
package dma_burst_pkg;
  import cf_math_pkg::idx_width;

  localparam int unsigned PageBytes    = 4096;
  localparam int unsigned AxLenWidth   = 8;
  localparam int unsigned MaxAddrWidth = 64;
  localparam int unsigned MaxLenWidth  = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    ISSUE,
    DONE
  } burst_state_e;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] addr;
    logic [AxLenWidth-1:0]   len;
    logic                    last;
  } burst_req_t;

  function automatic logic [MaxLenWidth:0] beats_of(input logic [MaxLenWidth-1:0] len,
                                                    input int unsigned beat_bytes);
    int unsigned           off;
    logic [MaxLenWidth-1:0] mask;
    off  = idx_width(beat_bytes);
    mask = (MaxLenWidth'(1) << off) - MaxLenWidth'(1);
    return {1'b0, len >> off} + (MaxLenWidth + 1)'(|(len & mask));
  endfunction

endpackage

// File: rtl/dma_burst_len_calc.sv
// dma_burst_len_calc: combinational beat count for the next burst.
//   cur_addr  : beat-aligned address of the next burst
//   rem_beats : beats still to issue for the command (non-zero when used)
//   n         : min(rem_beats, MaxBeats, beats left in the 4 KiB page)
//   last      : this burst finishes the command
module dma_burst_len_calc
  import dma_burst_pkg::*;
  import cf_math_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned RemWidth  = 30,
  parameter int unsigned MaxBeats  = 256
) (
  input  logic [AddrWidth-1:0] cur_addr,
  input  logic [RemWidth-1:0]  rem_beats,
  output logic [RemWidth-1:0]  n,
  output logic                 last
);

  localparam int unsigned BeatBytes = DataWidth / 8;
  localparam int unsigned OffW      = idx_width(BeatBytes);
  localparam int unsigned PageBeats = ceil_div(PageBytes, BeatBytes);

  logic [RemWidth-1:0] page_left;
  logic                unused_addr;

  // Beats until the page boundary; ranges 1..PageBeats.
  assign page_left = RemWidth'(PageBeats) - RemWidth'(cur_addr[11:OffW]);

  // Only the in-page beat index matters here.
  assign unused_addr = ^{cur_addr[AddrWidth-1:12], cur_addr[OffW-1:0]};

  always_comb begin
    n = rem_beats;
    if (n > RemWidth'(MaxBeats)) n = RemWidth'(MaxBeats);
    if (n > page_left)           n = page_left;
  end

  assign last = (n == rem_beats);

endmodule

// File: rtl/dma_burst_sched.sv
// dma_burst_sched: splits one (address, byte length) command into AXI bursts
// of at most MaxBeats beats that never cross a 4 KiB page.
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   cmd_valid_i/ready_o  : command handshake (ready only while idle)
//   cmd_addr_i, cmd_len_i: start address (sub-beat bits ignored), byte length
//   burst_valid_o/ready_i: burst handshake toward the AXI address channel
//   burst_addr_o/len_o   : beat-aligned burst address, AxLEN (beats-1)
//   burst_last_o         : final burst of the command
//   cmd_done_o           : one-cycle pulse after the command is fully issued
//   busy_o               : FSM is not idle
module dma_burst_sched
  import dma_burst_pkg::*;
  import cf_math_pkg::*;
#(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned LenWidth  = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned MaxBeats  = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [AddrWidth-1:0]  cmd_addr_i,
  input  logic [LenWidth-1:0]   cmd_len_i,
  output logic                  burst_valid_o,
  input  logic                  burst_ready_i,
  output logic [AddrWidth-1:0]  burst_addr_o,
  output logic [AxLenWidth-1:0] burst_len_o,
  output logic                  burst_last_o,
  output logic                  cmd_done_o,
  output logic                  busy_o
);

  localparam int unsigned BeatBytes = DataWidth / 8;
  localparam int unsigned OffW      = idx_width(BeatBytes);
  localparam int unsigned RemW      = LenWidth - OffW + 1;

  burst_state_e         state;
  logic [AddrWidth-1:0] cur_addr;
  logic [RemW-1:0]      rem_beats;
  burst_req_t           burst_q;
  logic                 burst_valid_q;
  logic                 cmd_ready_q;
  logic                 cmd_done_q;

  logic [RemW-1:0]      cmd_beats;
  logic [RemW-1:0]      calc_n;
  logic                 calc_last;
  logic                 unused_addr_lo;

  assign cmd_beats      = RemW'(beats_of(MaxLenWidth'(cmd_len_i), BeatBytes));
  assign unused_addr_lo = ^cmd_addr_i[OffW-1:0];

  dma_burst_len_calc #(
    .AddrWidth (AddrWidth),
    .DataWidth (DataWidth),
    .RemWidth  (RemW),
    .MaxBeats  (MaxBeats)
  ) u_len_calc (
    .cur_addr  (cur_addr),
    .rem_beats (rem_beats),
    .n         (calc_n),
    .last      (calc_last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cur_addr      <= '0;
      rem_beats     <= '0;
      burst_q       <= '0;
      burst_valid_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      cmd_done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_done_q <= 1'b0;
          // Ready is registered and reset low, so it rises on the first idle
          // cycle after reset and otherwise is set on the way out of DONE.
          if (!cmd_ready_q) begin
            cmd_ready_q <= 1'b1;
          end else if (cmd_valid_i) begin
            cmd_ready_q <= 1'b0;
            cur_addr    <= {cmd_addr_i[AddrWidth-1:OffW], {OffW{1'b0}}};
            rem_beats   <= cmd_beats;
            if (cmd_beats == '0) begin
              state      <= DONE;
              cmd_done_q <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          burst_q.addr  <= MaxAddrWidth'(cur_addr);
          burst_q.len   <= AxLenWidth'(calc_n - RemW'(1));
          burst_q.last  <= calc_last;
          rem_beats     <= rem_beats - calc_n;
          cur_addr      <= cur_addr + (AddrWidth'(calc_n) << OffW);
          burst_valid_q <= 1'b1;
          state         <= ISSUE;
        end
        ISSUE: begin
          if (burst_ready_i) begin
            burst_valid_q <= 1'b0;
            if (burst_q.last) begin
              state      <= DONE;
              cmd_done_q <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        DONE: begin
          cmd_done_q  <= 1'b0;
          cmd_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign burst_valid_o = burst_valid_q;
  assign burst_addr_o  = burst_q.addr[AddrWidth-1:0];
  assign burst_len_o   = burst_q.len;
  assign burst_last_o  = burst_q.last;
  assign cmd_done_o    = cmd_done_q;
  assign busy_o        = (state != IDLE);

endmodule

// File: tb/tb_dma_burst_sched.sv
// Bench for dma_burst_sched: instance 0 uses MaxBeats=256, instance 1 uses
// MaxBeats=16; both see the same commands and a shared burst_ready.
module tb_dma_burst_sched;

  localparam int unsigned AW = 64;
  localparam int unsigned LW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          burst_ready;

  logic          cmd_ready [2];
  logic          bv        [2];
  logic [AW-1:0] baddr     [2];
  logic [7:0]    blen      [2];
  logic          blast     [2];
  logic          done      [2];
  logic          busy      [2];

  always #5 clk = ~clk;

  dma_burst_sched #(
    .AddrWidth (AW), .LenWidth (LW), .DataWidth (64), .MaxBeats (256)
  ) u_dut0 (
    .clk_i (clk), .rst_i (rst),
    .cmd_valid_i (cmd_valid), .cmd_ready_o (cmd_ready[0]),
    .cmd_addr_i (cmd_addr), .cmd_len_i (cmd_len),
    .burst_valid_o (bv[0]), .burst_ready_i (burst_ready),
    .burst_addr_o (baddr[0]), .burst_len_o (blen[0]), .burst_last_o (blast[0]),
    .cmd_done_o (done[0]), .busy_o (busy[0])
  );

  dma_burst_sched #(
    .AddrWidth (AW), .LenWidth (LW), .DataWidth (64), .MaxBeats (16)
  ) u_dut1 (
    .clk_i (clk), .rst_i (rst),
    .cmd_valid_i (cmd_valid), .cmd_ready_o (cmd_ready[1]),
    .cmd_addr_i (cmd_addr), .cmd_len_i (cmd_len),
    .burst_valid_o (bv[1]), .burst_ready_i (burst_ready),
    .burst_addr_o (baddr[1]), .burst_len_o (blen[1]), .burst_last_o (blast[1]),
    .cmd_done_o (done[1]), .busy_o (busy[1])
  );

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic        last;
  } exp_t;

  exp_t sb [2][$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  bit hold_low = 1'b0;
  bit rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference split: bytes to the page end, converted to beats.
  task automatic model(input int d, input logic [63:0] addr, input logic [63:0] len,
                       input logic [63:0] maxb);
    logic [63:0] a;
    logic [63:0] beats;
    logic [63:0] room;
    logic [63:0] n;
    exp_t        e;
    a     = addr & ~64'h7;
    beats = (len + 64'd7) / 64'd8;
    while (beats != 64'd0) begin
      room = (64'd4096 - (a % 64'd4096)) / 64'd8;
      n    = beats;
      if (n > maxb) n = maxb;
      if (n > room) n = room;
      e.addr = a;
      e.len  = 8'(n - 64'd1);
      e.last = (n == beats);
      sb[d].push_back(e);
      a     = a + n * 64'd8;
      beats = beats - n;
    end
  endtask

  initial begin
    burst_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      burst_ready = hold_low ? 1'b0 : (rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
    end
  end

  // Monitor / scoreboard state per instance.
  bit            done_due [2];
  bit            stall    [2];
  bit            pend     [2];
  int            exp_vcyc [2];
  int            rdy_cyc  [2];
  logic [AW-1:0] h_addr   [2];
  logic [7:0]    h_len    [2];
  logic          h_last   [2];

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        done_due[d] = 1'b0;
        stall[d]    = 1'b0;
        pend[d]     = 1'b0;
        exp_vcyc[d] = -1;
        rdy_cyc[d]  = -1;
      end else begin
        if (done[d] || done_due[d])
          check($sformatf("done_pulse%0d", d), 64'(done[d]), 64'(done_due[d]));
        done_due[d] = 1'b0;
        if (cyc == rdy_cyc[d])
          check($sformatf("ready_after_done%0d", d), 64'(cmd_ready[d]), 64'd1);
        if (done[d]) rdy_cyc[d] = cyc + 1;

        if (cmd_valid && cmd_ready[d]) begin
          if (cmd_len == '0) done_due[d] = 1'b1;
          else               exp_vcyc[d] = cyc + 2;
        end

        if (stall[d]) begin
          check($sformatf("stall_valid%0d", d), 64'(bv[d]), 64'd1);
          check($sformatf("stall_addr%0d", d), baddr[d], h_addr[d]);
          check($sformatf("stall_len%0d", d), 64'(blen[d]), 64'(h_len[d]));
          check($sformatf("stall_last%0d", d), 64'(blast[d]), 64'(h_last[d]));
        end

        if (bv[d] && !pend[d])
          check($sformatf("valid_latency%0d", d), 64'(cyc), 64'(exp_vcyc[d]));

        if (bv[d] && burst_ready) begin
          if (sb[d].size() == 0) begin
            check($sformatf("unexpected_burst%0d", d), 64'd1, 64'd0);
          end else begin
            e = sb[d].pop_front();
            check($sformatf("burst_addr%0d", d), baddr[d], e.addr);
            check($sformatf("burst_len%0d", d), 64'(blen[d]), 64'(e.len));
            check($sformatf("burst_last%0d", d), 64'(blast[d]), 64'(e.last));
          end
          if (blast[d]) done_due[d] = 1'b1;
          else          exp_vcyc[d] = cyc + 2;
        end

        stall[d]  = bv[d] && !burst_ready;
        pend[d]   = bv[d] && !burst_ready;
        h_addr[d] = baddr[d];
        h_len[d]  = blen[d];
        h_last[d] = blast[d];
      end
    end
  end

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (!(cmd_ready[0] && cmd_ready[1] && sb[0].size() == 0 && sb[1].size() == 0)) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 20000) begin
        check({tag, "_timeout"}, 64'd1, 64'd0);
        return;
      end
    end
  endtask

  task automatic run_cmd(input logic [63:0] addr, input logic [31:0] len);
    wait_idle("pre_cmd");
    model(0, addr, 64'(len), 64'd256);
    model(1, addr, 64'(len), 64'd16);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_idle("cmd");
  endtask

  initial begin
    int t;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_ready%0d", d), 64'(cmd_ready[d]), 64'd0);
      check($sformatf("rst_valid%0d", d), 64'(bv[d]), 64'd0);
      check($sformatf("rst_addr%0d", d), baddr[d], 64'd0);
      check($sformatf("rst_len%0d", d), 64'(blen[d]), 64'd0);
      check($sformatf("rst_done%0d", d), 64'(done[d]), 64'd0);
      check($sformatf("rst_busy%0d", d), 64'(busy[d]), 64'd0);
    end
    rst = 1'b0;

    run_cmd(64'h1000, 32'd64);
    run_cmd(64'h0FF0, 32'd64);
    run_cmd(64'h0000, 32'd4096);
    run_cmd(64'h2003, 32'd13);
    run_cmd(64'h2003, 32'd0);
    run_cmd(64'h0FFF, 32'd1);
    run_cmd(64'h3F00, 32'd8192);

    rand_rdy = 1'b1;
    for (int i = 0; i < 12; i++)
      run_cmd(64'($urandom_range(0, 65535)), 32'($urandom_range(0, 3000)));
    rand_rdy = 1'b0;

    // Stall the first burst, then reset mid-command.
    wait_idle("pre_stall");
    hold_low    = 1'b1;
    burst_ready = 1'b0;
    model(0, 64'h0, 64'd4096, 64'd256);
    model(1, 64'h0, 64'd4096, 64'd16);
    cmd_valid = 1'b1;
    cmd_addr  = 64'h0;
    cmd_len   = 32'd4096;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    t = 0;
    while (!bv[0] && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stall_wait_valid", 64'(bv[0]), 64'd1);
    repeat (10) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("hold_valid%0d", d), 64'(bv[d]), 64'd1);
        check($sformatf("hold_addr%0d", d), baddr[d], 64'h0);
        check($sformatf("hold_len%0d", d), 64'(blen[d]), (d == 0) ? 64'd255 : 64'd15);
        check($sformatf("hold_ready%0d", d), 64'(cmd_ready[d]), 64'd0);
        check($sformatf("hold_busy%0d", d), 64'(busy[d]), 64'd1);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("arst_valid%0d", d), 64'(bv[d]), 64'd0);
      check($sformatf("arst_addr%0d", d), baddr[d], 64'd0);
      check($sformatf("arst_len%0d", d), 64'(blen[d]), 64'd0);
      check($sformatf("arst_last%0d", d), 64'(blast[d]), 64'd0);
      check($sformatf("arst_done%0d", d), 64'(done[d]), 64'd0);
      check($sformatf("arst_busy%0d", d), 64'(busy[d]), 64'd0);
      check($sformatf("arst_ready%0d", d), 64'(cmd_ready[d]), 64'd0);
      sb[d].delete();
    end
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    hold_low = 1'b0;

    run_cmd(64'h1000, 32'd64);
    repeat (4) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("end_queue%0d", d), 64'(sb[d].size()), 64'd0);
      check($sformatf("end_busy%0d", d), 64'(busy[d]), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dma_burst_sched.md
# dma_burst_sched

Burst scheduler for the DMA read/write front end. It accepts one transfer command (start address, byte length) at a time and splits it into AXI-legal bursts. Each burst is limited to MaxBeats beats and never crosses a 4 KiB page. The bursts are issued on a valid/ready port toward the AXI address channel driver. Beat counts use ceiling division of the byte length by the bus width in bytes.

## Interface
Parameters:
- AddrWidth, 64, transfer and burst address width
- LenWidth, 32, command byte-length width
- DataWidth, 64, AXI data width in bits; power of two, ≥8
- MaxBeats, 256, max beats per burst; power of two, 1..256

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready; high only in IDLE
- cmd_addr_i  in  AddrWidth  start address; low OffW bits treated as zero
- cmd_len_i  in  LenWidth  length in bytes
- burst_valid_o  out  1  burst valid
- burst_ready_i  in  1  burst ready
- burst_addr_o  out  AddrWidth  burst start address, beat-aligned
- burst_len_o  out  8  AXI AxLEN (beats−1)
- burst_last_o  out  1  final burst of the command
- cmd_done_o  out  1  one-cycle pulse when the command is fully issued
- busy_o  out  1  high whenever the state is not IDLE

## Operation
- BeatBytes = DataWidth/8. OffW = idx_width(BeatBytes). PageBeats = 4096/BeatBytes.
- Registers:
  - cur_addr (AddrWidth)
  - rem_beats (LenWidth−OffW+1 bits)
  - burst fields
- Command acceptance:
  - cmd_valid_i && cmd_ready_o accepts the command.
  - rem_beats = (cmd_len_i >> OffW) + (|cmd_len_i[OffW-1:0]), which is ceil_div(len, BeatBytes).
  - cur_addr = cmd_addr_i with the low OffW bits zeroed.
- Beats per burst: n = min(rem_beats, MaxBeats, PageBeats − cur_addr[11:OffW]). The page term ranges 1..PageBeats.
- States:
  - IDLE:
    - cmd_ready_o=1.
    - On accept: go to DONE if rem_beats==0, else go to CALC.
  - CALC (1 cycle):
    - Register burst_addr_o=cur_addr, burst_len_o=n−1, burst_last_o=(n==rem_beats).
    - Update rem_beats −= n and cur_addr += n·BeatBytes.
    - Go to ISSUE.
  - ISSUE:
    - burst_valid_o=1.
    - On handshake: go to DONE if burst_last_o, else go to CALC.
  - DONE (1 cycle): cmd_done_o=1, then go to IDLE.
- Address arithmetic is modulo 2^AddrWidth. Wrap at the top of the address space is not flagged.
- Burst count grows as follows; intermediate products are computed at full width:
  - len=1 gives one beat.
  - len=2^LenWidth−1 gives ceil(len/BeatBytes) beats.

## Timing
- Reset values: every output is 0, state is IDLE, all registers are 0.
- Command accepted at cycle N: CALC is at N+1 and burst_valid_o is first high at N+2.
- After a non-last burst handshake at cycle M, the next burst_valid_o is at M+2. There is one CALC bubble between bursts.
- After the last burst handshake at M, cmd_done_o pulses at M+1. cmd_ready_o is high again from M+2.
- A zero-length command accepted at N produces no bursts. cmd_done_o pulses at N+1.
- Valid/ready rules:
  - burst_valid_o is never withdrawn once asserted without a handshake.
  - burst_addr_o, burst_len_o and burst_last_o are stable while burst_valid_o && !burst_ready_i.
  - cmd_ready_o does not depend combinationally on cmd_valid_i.
- Reset asserted mid-command drops the command immediately, asynchronously: all outputs go to 0 and no cmd_done_o pulse is produced.

## Structure
- The shared package dma_burst_pkg holds:
  - PageBytes=4096
  - the AxLEN width constant (8)
  - the function beats_of(len, BeatBytes) (ceiling division via shift/OR)
  - the state enum typedef burst_state_e {IDLE, CALC, ISSUE, DONE}
  - the burst_req_t struct {addr, len, last}
- idx_width and ceil_div are taken from cf_math_pkg.
- Sub-module dma_burst_len_calc (combinational): inputs cur_addr and rem_beats; outputs n and last. It can be unit-tested standalone.

## Test plan
Parameters DataWidth=64 (BeatBytes=8) and MaxBeats=256 unless noted.
- addr 0x1000, len 64 → one burst: addr 0x1000, len 7, last=1. cmd_done_o pulses one cycle after the handshake.
- addr 0x0FF0, len 64 → burst 0x0FF0/len 1 (last=0), then burst 0x1000/len 5 (last=1).
- addr 0x0, len 4096 → bursts 0x0/len 255 and 0x800/len 255. With MaxBeats=16 the same command gives 32 bursts of len 15, addresses stepping by 0x80.
- addr 0x2003, len 13 → one burst: addr 0x2000, len 1, last=1. Then len 0 → no burst, cmd_done_o pulses at N+1.
- burst_ready_i held low for 10 cycles during ISSUE → outputs stay stable and cmd_ready_o stays 0. Then rst_i is pulsed mid-command → outputs go to 0 with no done pulse. The next command executes normally.
